// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back for the
// processor datapath and handshakes with data memory through MEM_Req/Mem_Ack.
module multicycle_control #(
    parameter int WAIT_MAX = 15
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Mem_Ack,
    output logic        PC_sel,
    output logic        PC_LdEn,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        MEM_Req,
    output logic        MEM_WrEn,
    output logic        Byte_op,
    output logic        Illegal,
    output logic        Bus_Err,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_EXEC_BR  = 4'd4,
        S_BRANCH   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_ACC  = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_ILLEGAL  = 4'd10
    } state_t;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_wait_cnt;
    logic        r_illegal;
    logic        r_bus_err;
    logic [5:0]  w_op;
    logic [3:0]  w_imm_func;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_rfb;
    logic        w_timeout;
    logic        w_unused;

    assign w_op       = Instr[31:26];
    assign w_imm_func = (w_op == OP_ANDI) ? 4'b0010 :
                        (w_op == OP_ORI)  ? 4'b0011 : 4'b0000;
    assign w_is_store = (w_op == OP_SB) || (w_op == OP_SW);
    assign w_is_byte  = (w_op == OP_LB) || (w_op == OP_SB);
    assign w_rfb      = (w_op == OP_BEQ) || (w_op == OP_BNE) || w_is_store;
    assign w_timeout  = (r_state == S_MEM_ACC) && !Mem_Ack && (r_wait_cnt == WAIT_LAST);
    assign w_unused   = ^Instr[25:4];

    assign State   = r_state;
    assign Illegal = r_illegal;
    assign Bus_Err = r_bus_err;

    // State register, memory wait counter and sticky error flags
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_MEM_ADDR) begin
                r_wait_cnt <= 8'd0;
            end else if ((r_state == S_MEM_ACC) && !Mem_Ack) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
            if (r_state == S_ILLEGAL) begin
                r_illegal <= 1'b1;
            end else begin
                r_illegal <= r_illegal;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end else begin
                r_bus_err <= r_bus_err;
            end
        end
    end

    // Next-state and control outputs, decoded from the current state
    always_comb begin
        w_next_state  = S_FETCH;
        PC_sel        = 1'b0;
        PC_LdEn       = 1'b0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = 4'b0000;
        MEM_Req       = 1'b0;
        MEM_WrEn      = 1'b0;
        Byte_op       = 1'b0;
        case (r_state)
            S_FETCH: begin
                IR_LdEn      = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                RF_B_sel = w_rfb;
                case (w_op)
                    OP_R:                                  w_next_state = S_EXEC_R;
                    OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: w_next_state = S_EXEC_I;
                    OP_B:                                  w_next_state = S_BRANCH;
                    OP_BEQ, OP_BNE:                        w_next_state = S_EXEC_BR;
                    OP_LB, OP_LW, OP_SB, OP_SW:            w_next_state = S_MEM_ADDR;
                    default:                               w_next_state = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                ALU_func     = Instr[3:0];
                w_next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALU_Bin_sel  = 1'b1;
                ALU_func     = w_imm_func;
                w_next_state = S_WB_ALU;
            end
            S_WB_ALU: begin
                // ALU operands stay selected so the result is stable while written back
                if (w_op == OP_R) begin
                    ALU_func = Instr[3:0];
                end else begin
                    ALU_Bin_sel = 1'b1;
                    ALU_func    = w_imm_func;
                end
                RF_WrEn       = 1'b1;
                RF_WrData_sel = 1'b1;
                PC_LdEn       = 1'b1;
            end
            S_EXEC_BR: begin
                RF_B_sel = 1'b1;
                ALU_func = 4'b0001;
                PC_LdEn  = 1'b1;
                PC_sel   = (w_op == OP_BEQ) ? Zero : ~Zero;
            end
            S_BRANCH: begin
                PC_LdEn = 1'b1;
                PC_sel  = 1'b1;
            end
            S_MEM_ADDR: begin
                ALU_Bin_sel  = 1'b1;
                w_next_state = S_MEM_ACC;
            end
            S_MEM_ACC: begin
                ALU_Bin_sel = 1'b1;
                MEM_Req     = 1'b1;
                MEM_WrEn    = w_is_store;
                Byte_op     = w_is_byte;
                RF_B_sel    = w_rfb;
                // An acknowledge on the final allowed cycle beats the timeout
                if (Mem_Ack) begin
                    if (w_is_store) begin
                        PC_LdEn      = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB_MEM;
                    end
                end else if (r_wait_cnt == WAIT_LAST) begin
                    PC_LdEn      = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEM_ACC;
                end
            end
            S_WB_MEM: begin
                RF_WrEn = 1'b1;
                Byte_op = w_is_byte;
                PC_LdEn = 1'b1;
            end
            S_ILLEGAL: begin
                PC_LdEn = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a table of instructions with expected per-instruction
// behaviour is pushed into a scoreboard and compared as each instruction retires.
module tb_multicycle_control;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] Instr;
    logic        Zero;
    logic        Mem_Ack;
    logic        PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_Req, MEM_WrEn, Byte_op, Illegal, Bus_Err;
    logic [3:0]  State;

    int total;
    int bad;

    multicycle_control #(.WAIT_MAX(15)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
        .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .MEM_Req(MEM_Req), .MEM_WrEn(MEM_WrEn), .Byte_op(Byte_op),
        .Illegal(Illegal), .Bus_Err(Bus_Err), .State(State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stimulus: opcode, func, Zero, MEM_ACC cycles before Mem_Ack (-1 = never),
    // Mem_Ack noise outside MEM_ACC. Expected: cycle count, first 8 states as hex
    // nibbles, write/PC/memory/ALU observations and sticky flags after retirement.
    typedef struct {
        logic [5:0]  op;
        logic [3:0]  func;
        logic        zero;
        int          wait_n;
        logic        noise;
        int          cyc;
        int          path;
        int          rfwr;
        int          wrsel;
        int          pcsel;
        int          memreq;
        int          memwr;
        int          byte_op;
        int          alu;
        int          bin;
        int          rfb;
        int          ill;
        int          bus;
    } vec_t;

    typedef struct {
        int cyc, path, rfwr, wrsel, pcld, pcsel, irld, memreq, memwr, byte_op;
        int alu, bin, rfb, ill, bus;
    } obs_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [5:0] op, input logic [3:0] func, input logic zero,
                                input int wait_n, input logic noise, input int cyc, input int path,
                                input int rfwr, input int wrsel, input int pcsel, input int memreq,
                                input int memwr, input int byte_op, input int alu, input int bin,
                                input int rfb, input int ill, input int bus);
        vec_t v;
        v.op = op; v.func = func; v.zero = zero; v.wait_n = wait_n; v.noise = noise;
        v.cyc = cyc; v.path = path; v.rfwr = rfwr; v.wrsel = wrsel; v.pcsel = pcsel;
        v.memreq = memreq; v.memwr = memwr; v.byte_op = byte_op; v.alu = alu; v.bin = bin;
        v.rfb = rfb; v.ill = ill; v.bus = bus;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one instruction from the current FETCH (at a falling edge) up to the next FETCH.
    task automatic run(input vec_t v, output obs_t o);
        int acc;
        logic [3:0] s;
        o = '{default: 0};
        acc = 0;
        Instr = {v.op, 22'd0, v.func};
        Zero = v.zero;
        o.cyc = 300;
        for (int c = 0; c < 300; c++) begin
            s = State;
            if (c > 0 && s == 4'd0) begin
                o.cyc = c;
                break;
            end
            if (s == 4'd7) begin
                Mem_Ack = (v.wait_n >= 0) && (acc == v.wait_n);
                acc++;
            end else begin
                Mem_Ack = v.noise;
            end
            #1;
            if (c < 8) o.path = (o.path << 4) | int'(s);
            if (c == 1) o.rfb = int'(RF_B_sel);
            if (c == 2) begin
                o.alu = int'(ALU_func);
                o.bin = int'(ALU_Bin_sel);
            end
            if (RF_WrEn) begin
                o.rfwr++;
                o.wrsel = int'(RF_WrData_sel);
            end
            if (PC_LdEn) begin
                o.pcld++;
                o.pcsel = int'(PC_sel);
            end
            if (IR_LdEn) o.irld++;
            if (MEM_Req) o.memreq++;
            if (MEM_WrEn) o.memwr = 1;
            if (Byte_op) o.byte_op = 1;
            @(negedge Clk);
        end
        Mem_Ack = 1'b0;
        #1;
        o.ill = int'(Illegal);
        o.bus = int'(Bus_Err);
    endtask

    task automatic compare(input int i, input vec_t e, input obs_t o);
        string p;
        p = $sformatf("row%0d_op%b", i, e.op);
        chk({p, "_cycles"}, o.cyc, e.cyc);
        chk({p, "_states"}, o.path, e.path);
        chk({p, "_rf_wr"}, o.rfwr, e.rfwr);
        chk({p, "_wrdata_sel"}, o.wrsel, e.wrsel);
        chk({p, "_pc_ld"}, o.pcld, 1);
        chk({p, "_pc_sel"}, o.pcsel, e.pcsel);
        chk({p, "_ir_ld"}, o.irld, 1);
        chk({p, "_mem_req"}, o.memreq, e.memreq);
        chk({p, "_mem_wr"}, o.memwr, e.memwr);
        chk({p, "_byte_op"}, o.byte_op, e.byte_op);
        chk({p, "_alu_func"}, o.alu, e.alu);
        chk({p, "_alu_bin"}, o.bin, e.bin);
        chk({p, "_rf_b_sel"}, o.rfb, e.rfb);
        chk({p, "_illegal"}, o.ill, e.ill);
        chk({p, "_bus_err"}, o.bus, e.bus);
    endtask

    initial begin
        obs_t o;
        vec_t e;
        int n;
        total = 0;
        bad = 0;
        //        op         fn    z     wt  nz  cyc path          rfw ws ps mreq mw by alu bin rfb ill bus
        tbl.push_back(mk(6'b100000, 4'h0, 1'b0, -1, 1'b0, 4, 'h0128,     1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b100000, 4'h5, 1'b0, -1, 1'b1, 4, 'h0128,     1, 1, 0, 0,  0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(6'b111000, 4'h0, 1'b0, -1, 1'b0, 4, 'h0138,     1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(6'b111001, 4'h7, 1'b0, -1, 1'b0, 4, 'h0138,     1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(6'b110000, 4'h0, 1'b0, -1, 1'b0, 4, 'h0138,     1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(6'b110010, 4'h0, 1'b0, -1, 1'b0, 4, 'h0138,     1, 1, 0, 0,  0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(6'b110011, 4'h0, 1'b0, -1, 1'b0, 4, 'h0138,     1, 1, 0, 0,  0, 0, 3, 1, 0, 0, 0));
        tbl.push_back(mk(6'b111111, 4'h0, 1'b0, -1, 1'b0, 3, 'h015,      0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b000000, 4'h0, 1'b1, -1, 1'b0, 3, 'h014,      0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(6'b000000, 4'h0, 1'b0, -1, 1'b1, 3, 'h014,      0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(6'b000001, 4'h0, 1'b0, -1, 1'b0, 3, 'h014,      0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(6'b000001, 4'h0, 1'b1, -1, 1'b0, 3, 'h014,      0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(6'b001111, 4'h0, 1'b0,  0, 1'b0, 5, 'h01679,    1, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0));
        // three MEM_ACC cycles without Mem_Ack, acknowledged on the fourth
        tbl.push_back(mk(6'b001111, 4'h0, 1'b0,  3, 1'b0, 8, 'h01677779, 1, 0, 0, 4,  0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(6'b000011, 4'h0, 1'b0,  1, 1'b0, 6, 'h016779,   1, 0, 0, 2,  0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(6'b011111, 4'h0, 1'b0,  0, 1'b0, 4, 'h0167,     0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(6'b000111, 4'h0, 1'b0,  2, 1'b0, 6, 'h016777,   0, 0, 0, 3,  1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(6'b001111, 4'h0, 1'b0, 14, 1'b0, 19, 'h01677777, 1, 0, 0, 15, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(6'b101010, 4'h0, 1'b0, -1, 1'b0, 3, 'h01A,      0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(6'b011111, 4'h0, 1'b0, -1, 1'b0, 18, 'h01677777, 0, 0, 0, 15, 1, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(6'b100000, 4'h0, 1'b0, -1, 1'b0, 4, 'h0128,     1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1));

        Rst_n = 1'b0;
        Instr = 32'd0;
        Zero = 1'b0;
        Mem_Ack = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        chk("reset_state", int'(State), 0);
        chk("reset_ir_ld", int'(IR_LdEn), 1);
        chk("reset_pc_ld", int'(PC_LdEn), 0);
        chk("reset_mem_req", int'(MEM_Req), 0);
        chk("reset_illegal", int'(Illegal), 0);
        chk("reset_bus_err", int'(Bus_Err), 0);
        Rst_n = 1'b1;

        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i]);
            run(tbl[i], o);
            e = exp_q.pop_front();
            compare(i, e, o);
        end

        // Reset while a load is waiting in MEM_ACC with both sticky flags set
        Instr = {6'b001111, 26'd0};
        n = 0;
        while (State != 4'd7 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        chk("midacc_reach", int'(State), 7);
        @(negedge Clk);
        #1;
        chk("midacc_req_before", int'(MEM_Req), 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        #1;
        chk("midacc_rst_state", int'(State), 0);
        chk("midacc_rst_req", int'(MEM_Req), 0);
        chk("midacc_rst_illegal", int'(Illegal), 0);
        chk("midacc_rst_bus_err", int'(Bus_Err), 0);
        Rst_n = 1'b1;
        e = mk(6'b100000, 4'h3, 1'b0, -1, 1'b0, 4, 'h0128, 1, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        exp_q.push_back(e);
        run(e, o);
        e = exp_q.pop_front();
        compare(99, e, o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
